// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one byte-serial SPI engine among NUM_REQ
// requesters. Grants whole bursts with chip-select held low.
// Ports: clk/reset; req/req_last/req_tx from requesters;
//   gnt/cs_n/byte_done/rx_data back to them; busy/err status;
//   eng_start/eng_tx/eng_rx/eng_done to/from the SPI engine.
module spi_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_tx,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   cs_n,
  output logic [NUM_REQ-1:0]   byte_done,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 err,
  output logic                 eng_start,
  output logic [7:0]           eng_tx,
  input  logic [7:0]           eng_rx,
  input  logic                 eng_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_XFER, S_NEXT, S_LOAD, S_GAP
  } state_t;

  state_t               r_state, w_state;
  logic [IW-1:0]        r_ptr, w_ptr;
  logic [IW-1:0]        r_g, w_g;
  logic                 r_last, w_last;
  logic [TO_W-1:0]      r_to, w_to;
  logic [GW-1:0]        r_gap, w_gap;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [NUM_REQ-1:0]   r_cs_n, w_cs_n;
  logic [NUM_REQ-1:0]   r_bd, w_bd;
  logic [7:0]           r_rx, w_rx;
  logic                 r_busy, w_busy;
  logic                 r_err, w_err;
  logic                 r_start, w_start;
  logic [7:0]           r_tx, w_tx;

  logic [7:0]           w_tx_arr [NUM_REQ];
  logic [7:0]           w_sel_tx;
  logic [IW-1:0]        w_pick;
  logic [IW-1:0]        w_g_inc;
  logic [NUM_REQ-1:0]   w_g_oh;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic                 w_to_gap;

  // First set request at or above the pointer, wrapping.
  // Scanning offsets downward lets the nearest one win.
  function automatic logic [IW-1:0] f_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IW-1:0]      p
  );
    logic [IW-1:0] s;
    int            idx;
    s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) s = IW'(idx);
    end
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_tx_arr[i] = req_tx[8*i +: 8];
  end

  assign w_sel_tx  = w_tx_arr[r_g];
  assign w_pick    = f_pick(req, r_ptr);
  assign w_pick_oh = NUM_REQ'(1) << w_pick;
  assign w_g_oh    = NUM_REQ'(1) << r_g;
  assign w_g_inc   = (r_g == IW'(NUM_REQ - 1)) ?
                     '0 : r_g + 1'b1;

  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_g      = r_g;
    w_last   = r_last;
    w_to     = r_to;
    w_gap    = r_gap;
    w_gnt    = r_gnt;
    w_cs_n   = r_cs_n;
    w_bd     = '0;
    w_rx     = r_rx;
    w_err    = 1'b0;
    w_start  = r_start;
    w_tx     = r_tx;
    w_to_gap = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_g     = w_pick;
          w_gnt   = w_pick_oh;
          w_cs_n  = ~w_pick_oh;
          w_state = S_SEL;
        end
      end
      S_SEL: begin
        w_tx    = w_sel_tx;
        w_last  = req_last[r_g];
        w_start = 1'b1;
        w_to    = '0;
        w_state = S_XFER;
      end
      S_XFER: begin
        // A done on the expiry cycle still counts as a good byte.
        if (eng_done) begin
          w_rx    = eng_rx;
          w_start = 1'b0;
          w_bd    = w_g_oh;
          if (r_last) w_to_gap = 1'b1;
          else        w_state  = S_NEXT;
        end else if (r_to == TO_W'(TIMEOUT_CYC - 1)) begin
          w_start  = 1'b0;
          w_err    = 1'b1;
          w_to_gap = 1'b1;
        end else begin
          w_to = r_to + 1'b1;
        end
      end
      S_NEXT: w_state = S_LOAD;
      S_LOAD: begin
        if (req[r_g]) begin
          w_tx    = w_sel_tx;
          w_last  = req_last[r_g];
          w_start = 1'b1;
          w_to    = '0;
          w_state = S_XFER;
        end else begin
          w_to_gap = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYCLES - 1)) w_state = S_IDLE;
        else w_gap = r_gap + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_to_gap) begin
      w_state = S_GAP;
      w_gnt   = '0;
      w_cs_n  = '1;
      w_ptr   = w_g_inc;
      w_gap   = '0;
    end
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_last  <= 1'b0;
      r_to    <= '0;
      r_gap   <= '0;
      r_gnt   <= '0;
      r_cs_n  <= '1;
      r_bd    <= '0;
      r_rx    <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_tx    <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_g     <= w_g;
      r_last  <= w_last;
      r_to    <= w_to;
      r_gap   <= w_gap;
      r_gnt   <= w_gnt;
      r_cs_n  <= w_cs_n;
      r_bd    <= w_bd;
      r_rx    <= w_rx;
      r_busy  <= w_busy;
      r_err   <= w_err;
      r_start <= w_start;
      r_tx    <= w_tx;
    end
  end

  assign gnt       = r_gnt;
  assign cs_n      = r_cs_n;
  assign byte_done = r_bd;
  assign rx_data   = r_rx;
  assign busy      = r_busy;
  assign err       = r_err;
  assign eng_start = r_start;
  assign eng_tx    = r_tx;

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one byte-serial SPI engine among NUM_REQ requesters using round-robin arbitration.
- Grants whole bursts (multi-byte, chip-select held) and sequences the engine's start/done handshake one byte at a time.
- Decodes a per-requester active-low chip select and returns each received byte to the granted requester.
- Sits between the client blocks (config loaders, sensor pollers) and the SPI engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 2, cycles all cs_n held high between bursts (>=1)
- TIMEOUT_CYC, 1024, max cycles waiting for eng_done per byte before abort
- TO_W, 11, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester burst request, held high for whole burst
- req_last  in  NUM_REQ  current byte is last of burst
- req_tx  in  NUM_REQ*8  per-requester tx byte, requester i at [8i+7:8i]
- gnt  out  NUM_REQ  one-hot grant, held for whole burst
- cs_n  out  NUM_REQ  active-low device select, low only for granted requester
- byte_done  out  NUM_REQ  one-cycle pulse to granted requester per completed byte
- rx_data  out  8  received byte, valid while byte_done is high, held afterwards
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on engine timeout
- eng_start  out  1  level start to engine, held until eng_done
- eng_tx  out  8  byte to engine, stable while eng_start high
- eng_rx  in  8  byte from engine, valid with eng_done
- eng_done  in  1  engine byte-complete pulse

Behaviour:
- Reset (async, immediate, also mid-burst):
  - gnt=0, cs_n=all 1, byte_done=0, rx_data=0, busy=0, err=0, eng_start=0, eng_tx=0.
  - State IDLE; round-robin pointer=0.
- Timing: all outputs registered.
- States: IDLE, SEL, XFER, NEXT, LOAD, GAP.
- IDLE:
  - If any req is high, pick the first set bit scanning upward from the pointer (wraps modulo NUM_REQ).
  - Next cycle: SEL, with gnt[g]=1 and cs_n[g]=0.
- SEL (1 cycle): at end of cycle, latch req_tx[g] into eng_tx and req_last[g] into last_q; go to XFER.
- XFER:
  - eng_start=1; timeout counter runs.
  - On eng_done: capture eng_rx, drop eng_start.
    - last_q=1: next cycle is GAP.
    - last_q=0: next cycle is NEXT.
  - In both cases byte_done[g]=1 and rx_data is valid on that next cycle.
- NEXT (1 cycle):
  - byte_done pulse; eng_start=0.
  - Requester updates req_tx/req_last on this edge.
- LOAD (1 cycle):
  - req[g] high: latch req_tx[g] and req_last[g], go to XFER.
  - req[g] low: abort; go to GAP without starting a byte and without a byte_done.
- GAP:
  - gnt=0 and cs_n all high on entry.
  - Pointer set to g+1 (mod NUM_REQ).
  - Hold GAP_CYCLES cycles, then IDLE.
  - On the final-byte path, byte_done coincides with the first GAP cycle.
- Timeout:
  - Counter reaches TIMEOUT_CYC-1 in XFER without eng_done: eng_start=0, err pulse 1 cycle, go to GAP.
  - No byte_done; rx_data unchanged.
  - If eng_done arrives on the expiry cycle, eng_done wins.
- req[g] dropped during XFER: current byte completes normally; abort is taken in LOAD.
- New requests during a burst are ignored until IDLE; no preemption.
- eng_done outside XFER is ignored.
- Minimum idle start between bytes of one burst is 2 cycles (NEXT, LOAD); eng_start is low for >=2 cycles.
- Throughput: a single-byte burst occupies 1 (SEL) + engine time + GAP_CYCLES cycles.

Test Plan:
- Single byte: req[1]=1, req_tx[1]=8'hA5, req_last[1]=1, engine returns 8'h3C after 16 cycles.
  - Response: gnt=4'b0010, cs_n=4'b1101, eng_tx=A5, byte_done[1] pulse with rx_data=3C.
  - Then cs_n=4'hF for 2 cycles, busy drops.
- 3-byte burst from req[0]: tx bytes 11,22,33 with last on the 3rd.
  - Response: three byte_done[0] pulses, cs_n[0] continuously low.
  - eng_start low exactly 2 cycles between bytes; eng_tx sequence 11,22,33.
- Round-robin: req=4'b1011 held, all single-byte.
  - Grant order 0,1,3,0,1,3; never two grants without a >=2-cycle all-high cs_n gap.
- Abort: req[2] burst with last=0; req[2] dropped during the 1st byte.
  - Response: 1st byte completes with byte_done; LOAD goes to GAP, no 2nd eng_start.
- Timeout: TIMEOUT_CYC=8, engine never asserts done.
  - Response: eng_start high 8 cycles, then err pulse, no byte_done, cs_n released, IDLE after GAP.
  - A subsequent request is served normally.
- Reset mid-XFER: all outputs return to reset values immediately; pointer=0 after release.
  - req=4'b1100 is then granted to requester 2 first.
